// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    localparam int unsigned REG_ADDR_W      = 4;
    localparam int unsigned MEM_TIMEOUT_DEF = 64;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } pipe_state_e;

    // Wait counter must be able to hold the timeout value itself.
    function automatic int unsigned wait_cnt_w(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with enable; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stage-register control (freeze/hazard/flush/mem_freeze) with memory-wait timeout and stall statistics.
// Define PIPE_FORWARDING_EN to restrict RAW stalls to the EXE load-use case.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] src1,
    input  logic [REG_ADDR_W-1:0] src2,
    input  logic                  two_src,
    input  logic [REG_ADDR_W-1:0] exe_dest,
    input  logic                  exe_wb_en,
    input  logic                  exe_mem_r_en,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  mem_wb_en,
    input  logic                  branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  freeze,
    output logic                  hazard,
    output logic                  flush,
    output logic                  mem_freeze,
    output logic                  mem_err,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam int unsigned WCNT_W = wait_cnt_w(MEM_TIMEOUT);
    localparam logic [WCNT_W-1:0] TIMEOUT_CNT = WCNT_W'(MEM_TIMEOUT);

    pipe_state_e       state_q, state_d;
    logic [WCNT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;
    logic              mem_freeze_raw;
    logic              hit1, hit2;

    always_comb begin
        state_d        = state_q;
        wait_d         = wait_q;
        err_d          = err_q;
        mem_freeze_raw = 1'b0;
        unique case (state_q)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    mem_freeze_raw = 1'b1;
                    state_d        = MEM_WAIT;
                    wait_d         = WCNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_d = RUN;
                    wait_d  = '0;
                end else if (wait_q == TIMEOUT_CNT) begin
                    // Access abandoned: release the pipeline and latch the error.
                    err_d   = 1'b1;
                    state_d = RUN;
                    wait_d  = '0;
                end else begin
                    mem_freeze_raw = 1'b1;
                    wait_d         = wait_q + 1'b1;
                end
            end
            default: begin
                state_d = RUN;
                wait_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

`ifdef PIPE_FORWARDING_EN
    logic unused_mem_fwd;
    assign unused_mem_fwd = mem_wb_en ^ (^mem_dest);
    assign hit1 = exe_mem_r_en & exe_wb_en & (exe_dest == src1);
    assign hit2 = two_src & exe_mem_r_en & exe_wb_en & (exe_dest == src2);
`else
    logic unused_exe_mem_r_en;
    assign unused_exe_mem_r_en = exe_mem_r_en;
    assign hit1 = (exe_wb_en & (exe_dest == src1)) | (mem_wb_en & (mem_dest == src1));
    assign hit2 = two_src & ((exe_wb_en & (exe_dest == src2)) | (mem_wb_en & (mem_dest == src2)));
`endif

    // All combinational controls are held low while reset is asserted.
    assign mem_freeze = rst & mem_freeze_raw;
    assign flush      = rst & branch_taken & ~mem_freeze;
    assign hazard     = rst & (hit1 | hit2) & ~flush & ~mem_freeze;
    assign freeze     = hazard;
    assign mem_err    = err_q;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk_i  (clk),
        .rst_ni (rst),
        .en_i   (freeze | mem_freeze),
        .cnt_o  (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk_i  (clk),
        .rst_ni (rst),
        .en_i   (flush),
        .cnt_o  (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl built with MEM_TIMEOUT=4, CNT_W=4.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] src1, src2, exe_dest, mem_dest;
    logic       two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
    logic       branch_taken, mem_req, mem_ready;
    logic       freeze, hazard, flush, mem_freeze, mem_err;
    logic [3:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .src1         (src1),
        .src2         (src2),
        .two_src      (two_src),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_r_en (exe_mem_r_en),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .freeze       (freeze),
        .hazard       (hazard),
        .flush        (flush),
        .mem_freeze   (mem_freeze),
        .mem_err      (mem_err),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    // Hazards that only exist without a forwarding unit.
`ifdef PIPE_FORWARDING_EN
    localparam int NF = 0;
`else
    localparam int NF = 1;
`endif

    typedef struct {
        string       name;
        logic [12:0] v;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [12:0] e(input logic f, input logic h, input logic fl,
                                      input logic mf, input logic err, input int sc, input int fc);
        return {f, h, fl, mf, err, 4'(sc), 4'(fc)};
    endfunction

    task automatic tick(input string n, input logic [12:0] v);
        exp_t x;
        x.name = n;
        x.v    = v;
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        src1 = '0; src2 = '0; exe_dest = '0; mem_dest = '0;
        two_src = 1'b0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; mem_wb_en = 1'b0;
        branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        tick("reset_pulse", e(0, 0, 0, 0, 0, 0, 0));
        rst = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t        x;
        logic [12:0] act;
        while (q.size() > 0) begin
            x   = q.pop_front();
            act = {freeze, hazard, flush, mem_freeze, mem_err, stall_cnt, flush_cnt};
            checks++;
            if (act !== x.v) begin
                failures++;
                $display("FAIL %s: got f=%b h=%b fl=%b mf=%b err=%b sc=%0d fc=%0d, expected f=%b h=%b fl=%b mf=%b err=%b sc=%0d fc=%0d",
                         x.name, act[12], act[11], act[10], act[9], act[8], act[7:4], act[3:0],
                         x.v[12], x.v[11], x.v[10], x.v[9], x.v[8], x.v[7:4], x.v[3:0]);
            end
        end
    end

    initial begin
        idle();
        rst = 1'b0;
        branch_taken = 1'b1; mem_req = 1'b1;
        src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1;
        @(posedge clk);
        #1;
        tick("reset_hold0", e(0, 0, 0, 0, 0, 0, 0));
        tick("reset_hold1", e(0, 0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        idle();
        tick("reset_release", e(0, 0, 0, 0, 0, 0, 0));

        // RAW detection
        src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1;
        tick("exe_raw", e(NF, NF, 0, 0, 0, 0, 0));
        exe_mem_r_en = 1'b1;
        tick("exe_load_use", e(1, 1, 0, 0, 0, NF, 0));
        idle();
        src1 = 4'd3; mem_dest = 4'd3; mem_wb_en = 1'b1;
        tick("mem_raw", e(NF, NF, 0, 0, 0, NF + 1, 0));
        idle();
        src2 = 4'd5; mem_dest = 4'd5; mem_wb_en = 1'b1; two_src = 1'b0;
        tick("two_src_gate", e(0, 0, 0, 0, 0, 2 * NF + 1, 0));
        do_reset();

        // Hazard plus branch: flush wins
        src2 = 4'd5; two_src = 1'b1; mem_dest = 4'd5; mem_wb_en = 1'b1;
        tick("src2_raw", e(NF, NF, 0, 0, 0, 0, 0));
        branch_taken = 1'b1;
        tick("hazard_branch", e(0, 0, 1, 0, 0, NF, 0));
        idle();
        tick("flush_count", e(0, 0, 0, 0, 0, NF, 1));
        do_reset();

        // Memory wait of 3 cycles; branch held until release
        mem_req = 1'b1;
        tick("wait_c1", e(0, 0, 0, 1, 0, 0, 0));
        branch_taken = 1'b1;
        tick("wait_c2_branch", e(0, 0, 0, 1, 0, 1, 0));
        src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1;
        tick("wait_c3_hazard", e(0, 0, 0, 1, 0, 2, 0));
        mem_ready = 1'b1;
        tick("wait_release", e(0, 0, 1, 0, 0, 3, 0));
        idle();
        tick("after_wait", e(0, 0, 0, 0, 0, 3, 1));
        mem_req = 1'b1; mem_ready = 1'b1;
        tick("single_cycle", e(0, 0, 0, 0, 0, 3, 1));
        idle();
        tick("single_cycle_after", e(0, 0, 0, 0, 0, 3, 1));
        do_reset();

        // Timeout after 4 frozen cycles
        mem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick("timeout_wait", e(0, 0, 0, 1, 0, i, 0));
        end
        tick("timeout_abort", e(0, 0, 0, 0, 0, 4, 0));
        mem_req = 1'b0;
        tick("timeout_err", e(0, 0, 0, 0, 1, 4, 0));
        tick("err_sticky", e(0, 0, 0, 0, 1, 4, 0));

        // Saturation of the 4-bit stall counter
        src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick("saturate", e(1, 1, 0, 0, 1, (4 + i > 15) ? 15 : 4 + i, 0));
        end
        idle();
        mem_req = 1'b1;
        tick("sat_wait_c1", e(0, 0, 0, 1, 1, 15, 0));
        tick("sat_wait_c2", e(0, 0, 0, 1, 1, 15, 0));

        // Asynchronous reset in the middle of MEM_WAIT
        rst = 1'b0;
        tick("async_reset", e(0, 0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        mem_req = 1'b0;
        tick("run_after_reset", e(0, 0, 0, 0, 0, 0, 0));

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
